// File: rtl/toggle_counter_n.sv
// toggle_counter_n: WIDTH-bit T flip-flop chain counter with programmable modulus
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset (q <= 0, wrap <= 0)
//   enable   - count enable, the T input of the chain
//   up       - 1 = count up, 0 = count down
//   load     - synchronous parallel load, overrides enable
//   load_val - value to load, clamped to MODULO-1
//   q        - registered count, 0..MODULO-1
//   tc       - combinational terminal count, for cascading into the next stage
//   wrap     - registered one-cycle pulse after a wrap edge
// Macro TOGGLE_COUNTER_SAT_EN selects saturating mode: hold at the limits, wrap tied 0.
module toggle_counter_n #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_load;
    logic             carry_up;
    logic             carry_dn;
    // Bit k toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        t        = '0;
        carry_up = enable;
        carry_dn = enable;
        for (int k = 0; k < WIDTH; k++) begin
            t[k]     = up ? carry_up : carry_dn;
            carry_up = carry_up & q[k];
            carry_dn = carry_dn & ~q[k];
        end
    end
    assign tc     = enable & (up ? (q == LAST) : (q == '0));
    assign q_load = (load_val > LAST) ? LAST : load_val;
    // Terminal count overrides the natural binary toggle so non-power-of-2 moduli wrap.
`ifdef TOGGLE_COUNTER_SAT_EN
    assign q_step = tc ? q : (q ^ t);
    assign wrap   = 1'b0;
`else
    assign q_step = tc ? (up ? '0 : LAST) : (q ^ t);
    always_ff @(posedge clk) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= tc & ~load;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= q_load;
        else if (enable)
            q <= q_step;
    end
endmodule

// File: tb/tb_toggle_counter_n.sv
// tb_toggle_counter_n: scoreboard bench for a MODULO=10 counter and a WIDTH=1 T flip-flop instance
module tb_toggle_counter_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, up, load;
    logic [3:0] load_val, q;
    logic       tc, wrap;
    logic       b_reset, b_enable, b_up, b_load;
    logic [0:0] b_load_val, b_q;
    logic       b_tc, b_wrap;

    toggle_counter_n #(.WIDTH(4), .MODULO(10)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap));
    toggle_counter_n #(.WIDTH(1), .MODULO(2)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .up(b_up), .load(b_load),
        .load_val(b_load_val), .q(b_q), .tc(b_tc), .wrap(b_wrap));

    typedef struct { int q; bit w; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int fails  = 0;
    int mq_a, mq_b;
    bit mw_a, mw_b;

    function automatic bit model_tc(input int m, input bit e, input bit u, input int cq);
        return e && ((u && cq == m - 1) || (!u && cq == 0));
    endfunction

    function automatic void model(input int m, input bit r, input bit l, input bit e,
                                  input bit u, input int lv, inout int cq, inout bit cw);
        bit t;
        t = model_tc(m, e, u, cq);
        if (r) begin
            cq = 0; cw = 0;
        end else if (l) begin
            cq = (lv > m - 1) ? m - 1 : lv; cw = 0;
        end else if (e) begin
`ifdef TOGGLE_COUNTER_SAT_EN
            if (!t) cq = u ? cq + 1 : cq - 1;
            cw = 0;
`else
            cq = u ? ((cq == m - 1) ? 0 : cq + 1) : ((cq == 0) ? m - 1 : cq - 1);
            cw = t;
`endif
        end else begin
            cw = 0;
        end
    endfunction

    task automatic step_a(input string tag, input bit r, input bit l, input bit e,
                          input bit u, input int lv);
        exp_t x;
        bit et;
        @(negedge clk);
        reset = r; load = l; enable = e; up = u; load_val = lv[3:0];
        #1;
        et = model_tc(10, e, u, mq_a);
        checks++;
        if (tc !== et) begin
            fails++;
            $display("FAIL %s tc: got %b expected %b (q=%0d)", tag, tc, et, mq_a);
        end
        model(10, r, l, e, u, lv, mq_a, mw_a);
        sb.push_back('{mq_a, mw_a});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks += 2;
        if (q !== x.q[3:0]) begin
            fails++;
            $display("FAIL %s q: got %0d expected %0d", tag, q, x.q);
        end
        if (wrap !== x.w) begin
            fails++;
            $display("FAIL %s wrap: got %b expected %b", tag, wrap, x.w);
        end
    endtask

    task automatic step_b(input string tag, input bit r, input bit e);
        exp_t x;
        bit et;
        @(negedge clk);
        b_reset = r; b_enable = e; b_up = 1'b1; b_load = 1'b0; b_load_val = 1'b0;
        #1;
        et = model_tc(2, e, 1'b1, mq_b);
        checks++;
        if (b_tc !== et) begin
            fails++;
            $display("FAIL %s tc: got %b expected %b", tag, b_tc, et);
        end
        model(2, r, 1'b0, e, 1'b1, 0, mq_b, mw_b);
        sb.push_back('{mq_b, mw_b});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks += 2;
        if (b_q !== x.q[0:0]) begin
            fails++;
            $display("FAIL %s q: got %0d expected %0d", tag, b_q, x.q);
        end
        if (b_wrap !== x.w) begin
            fails++;
            $display("FAIL %s wrap: got %b expected %b", tag, b_wrap, x.w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; load_val = '0;
        b_reset = 1'b1; b_load = 1'b0; b_enable = 1'b0; b_up = 1'b1; b_load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (q !== 4'd0) begin fails++; $display("FAIL reset q: got %0d expected 0", q); end
        if (wrap !== 1'b0) begin fails++; $display("FAIL reset wrap: got %b expected 0", wrap); end
        if (tc !== 1'b0) begin fails++; $display("FAIL reset tc: got %b expected 0", tc); end
        if (b_q !== 1'b0) begin fails++; $display("FAIL reset b_q: got %0d expected 0", b_q); end
        mq_a = 0; mw_a = 0; mq_b = 0; mw_b = 0;
    endtask

    task automatic test_tff();
        step_b("tff_reset", 1, 0);
        for (int i = 0; i < 6; i++) step_b("tff_toggle", 0, 1);
        for (int i = 0; i < 2; i++) step_b("tff_hold", 0, 0);
        step_b("tff_enable", 0, 1);
        step_b("tff_reset2", 1, 1);
    endtask

    task automatic test_mod10_up();
        step_a("up_reset", 1, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) step_a("up_count", 0, 0, 1, 1, 0);
        step_a("up_hold", 0, 0, 0, 1, 0);
    endtask

    task automatic test_down_flip();
        step_a("dn_load", 0, 1, 0, 0, 2);
        for (int i = 0; i < 3; i++) step_a("dn_count", 0, 0, 1, 0, 0);
        step_a("dn_flip", 0, 0, 1, 1, 0);
        step_a("dn_after", 0, 0, 1, 1, 0);
    endtask

    task automatic test_load_clamp();
        step_a("ld_clamp", 0, 1, 1, 1, 12);
        step_a("ld_max", 0, 1, 1, 0, 15);
        step_a("ld_exact", 0, 1, 0, 1, 9);
        step_a("ld_wrap_blocked", 0, 1, 1, 1, 4);
        step_a("ld_vs_reset", 1, 1, 1, 1, 7);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step_a("mid_count", 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) step_a("mid_reset", 1, 0, 1, 1, 0);
        step_a("mid_restart", 0, 0, 1, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++)
            step_a("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)));
    endtask

    initial begin
        test_reset();
        test_tff();
        test_mod10_up();
        test_down_flip();
        test_load_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
